echo_measure: RTL and testbench
===============================

ECHO_MEASURE -- requirements
Module: echo_measure

Interface
REQ-001 Parameter WAIT_MAX, default 30000: max cycles from trig falling edge to synchronized echo rise.
REQ-002 Parameter ECHO_MAX, default 38000: max cycles of echo high before the measurement is abandoned.
REQ-003 Parameter US_PER_CM, default 58: echo-high cycles per centimetre.
REQ-004 clk_1m  input  1  single 1 MHz clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 trig  input  1  trigger pulse from the upstream trigger generator, synchronous to clk_1m.
REQ-007 echo  input  1  raw sensor echo, asynchronous.
REQ-008 width_us  output  16  echo-high width of the last completed measurement, in cycles.
REQ-009 dist_cm  output  10  distance of the last completed measurement, floor(width_us / US_PER_CM).
REQ-010 valid  output  1  one-cycle pulse when width_us/dist_cm update.
REQ-011 timeout  output  1  one-cycle pulse when a measurement is abandoned.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The echo input SHALL pass through a two-flop synchronizer before any use; rise/fall SHALL be detected on the synchronized signal.
REQ-014 FSM states SHALL be IDLE, WAIT_RISE, MEASURE, DRAIN.
REQ-015 IDLE -> WAIT_RISE on the falling edge of trig (trig high last cycle, low this cycle); the wait counter clears.
REQ-016 WAIT_RISE -> MEASURE on synchronized echo rise; width and cm counters clear to 0 and sub-counter to 0.
REQ-017 WAIT_RISE -> IDLE with timeout pulse when the wait counter reaches WAIT_MAX without echo rise.
REQ-018 In MEASURE each cycle with synchronized echo high SHALL increment the width counter and the sub-counter; when the sub-counter reaches US_PER_CM-1 it SHALL wrap to 0 and increment the cm counter (no divider).
REQ-019 MEASURE -> IDLE on synchronized echo fall; in that same cycle width_us and dist_cm SHALL load the counters and valid SHALL pulse on the next cycle's output (registered, one-cycle latency from fall detection).
REQ-020 MEASURE -> DRAIN with timeout pulse when the width counter reaches ECHO_MAX; DRAIN -> IDLE when synchronized echo is low.
REQ-021 If synchronized echo is already high when entering WAIT_RISE, no rise SHALL be recognised until it goes low and high again.
REQ-022 trig edges outside IDLE SHALL be ignored; the measurement in progress continues.
REQ-023 valid and timeout SHALL never assert in the same cycle; width_us/dist_cm SHALL hold their values on timeout.
REQ-024 Counters SHALL saturate, never wrap: width at ECHO_MAX, wait at WAIT_MAX.

Reset
REQ-025 rst SHALL force state IDLE, synchronizer flops 0, all counters 0, width_us 0, dist_cm 0, valid 0, timeout 0, busy 0.
REQ-026 rst asserted mid-measurement SHALL discard it with no valid or timeout pulse.

Structure
REQ-027 Default values for WAIT_MAX, ECHO_MAX, US_PER_CM and the state encodings SHALL live in the shared ultrasonic package/header used by the trigger generator and display blocks.
REQ-028 One sub-module, sync_edge (two-flop synchronizer with registered rise/fall pulses), SHALL be instantiated for echo.

Verification
REQ-029 trig pulse, echo high 580 cycles starting 200 cycles after trig fall -> valid once, width_us=580, dist_cm=10, timeout never.
REQ-030 echo high 57 cycles -> dist_cm=0, width_us=57; echo high 116 -> dist_cm=2.
REQ-031 trig, no echo -> timeout pulse exactly WAIT_MAX=30000 cycles (+/-2 synchronizer) after trig fall, busy low after, width_us/dist_cm unchanged.
REQ-032 echo held high 50000 cycles -> timeout at width 38000, busy stays high until echo low, then IDLE; no valid.
REQ-033 second trig during MEASURE of a 1160-cycle echo -> ignored, single valid with dist_cm=20.
REQ-034 rst pulsed at cycle 300 of a 580-cycle echo -> all outputs 0, no valid/timeout; next trig + 290-cycle echo -> dist_cm=5.

Source files
------------

// File: rtl/echo_measure_pkg.sv
// Shared ultrasonic ranging definitions: default timing limits, result bus
// widths and the echo-measurement FSM state encoding. Used by the trigger
// generator, echo_measure and the display blocks.
package echo_measure_pkg;

   localparam int unsigned WAIT_MAX_DEF  = 30000;
   localparam int unsigned ECHO_MAX_DEF  = 38000;
   localparam int unsigned US_PER_CM_DEF = 58;

   localparam int WIDTH_W = 16;
   localparam int DIST_W  = 10;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_RISE = 2'd1,
      ST_MEASURE   = 2'd2,
      ST_DRAIN     = 2'd3
   } state_t;

endpackage

// File: rtl/echo_measure_if.sv
// Result bus of the echo measurement block.
//   width_us : echo-high width of the last completed measurement, in cycles
//   dist_cm  : distance of the last completed measurement, in centimetres
//   valid    : one-cycle pulse when width_us/dist_cm update
//   timeout  : one-cycle pulse when a measurement is abandoned
//   busy     : high while a measurement is in progress
// master = producer (echo_measure), slave = consumer (display, bench).
interface echo_measure_if;
   import echo_measure_pkg::*;

   logic [WIDTH_W-1:0] width_us;
   logic [DIST_W-1:0]  dist_cm;
   logic               valid;
   logic               timeout;
   logic               busy;

   modport master (output width_us, dist_cm, valid, timeout, busy);
   modport slave  (input  width_us, dist_cm, valid, timeout, busy);

endinterface

// File: rtl/echo_measure_sync_edge.sv
// Two-flop synchronizer with registered level and edge pulses.
//   clk   : sampling clock
//   rst   : synchronous active-high reset
//   din   : asynchronous input
//   level : synchronized level (one register after the synchronizer)
//   rise  : one-cycle pulse, coincident with the first high cycle of level
//   fall  : one-cycle pulse, coincident with the first low cycle of level
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic ff1;
   logic ff2;

   always_ff @(posedge clk) begin
      if (rst) begin
         ff1   <= 1'b0;
         ff2   <= 1'b0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         ff1   <= din;
         ff2   <= ff1;
         level <= ff2;
         rise  <= ff2 & ~level;
         fall  <= ~ff2 & level;
      end
   end

endmodule

// File: rtl/echo_measure.sv
// Ultrasonic echo width / distance measurement.
//   clk_1m : 1 MHz clock, all logic on the rising edge
//   rst    : synchronous active-high reset
//   trig   : trigger pulse (synchronous); its falling edge arms a measurement
//   echo   : raw asynchronous sensor echo
//   res    : result bus (width_us, dist_cm, valid, timeout, busy)
//
// state        | meaning
// ST_IDLE      | waiting for a trig falling edge
// ST_WAIT_RISE | armed, waiting for echo to rise (bounded by WAIT_MAX cycles)
// ST_MEASURE   | echo high, counting width and centimetres
// ST_DRAIN     | width hit ECHO_MAX, waiting for echo to drop
module echo_measure
   import echo_measure_pkg::*;
#(
   parameter int unsigned WAIT_MAX  = WAIT_MAX_DEF,
   parameter int unsigned ECHO_MAX  = ECHO_MAX_DEF,
   parameter int unsigned US_PER_CM = US_PER_CM_DEF
) (
   input  logic          clk_1m,
   input  logic          rst,
   input  logic          trig,
   input  logic          echo,
   echo_measure_if.master res
);

   localparam logic [15:0] WAIT_LOAD = 16'(WAIT_MAX);
   localparam logic [15:0] ECHO_LAST = 16'(ECHO_MAX);
   localparam logic [15:0] SUB_LAST  = 16'(US_PER_CM - 1);

   state_t             state;
   logic               trig_d;
   logic [15:0]        wait_cnt;
   logic [15:0]        width_cnt;
   logic [15:0]        sub_cnt;
   logic [DIST_W-1:0]  cm_cnt;
   logic [WIDTH_W-1:0] width_q;
   logic [DIST_W-1:0]  dist_q;
   logic               valid_q;
   logic               timeout_q;
   logic               busy_q;

   logic               echo_lvl;
   logic               echo_rise;
   logic               echo_fall;

   logic [15:0]        width_nx;
   logic [15:0]        sub_nx;
   logic [DIST_W-1:0]  cm_nx;
   logic               hit_max;

   sync_edge u_sync_echo (
      .clk   (clk_1m),
      .rst   (rst),
      .din   (echo),
      .level (echo_lvl),
      .rise  (echo_rise),
      .fall  (echo_fall)
   );

   // One counted echo-high cycle. The rise cycle itself already has echo
   // high, so it counts from cleared counters; in MEASURE it continues.
   always_comb begin
      width_nx = 16'd1;
      sub_nx   = 16'd1;
      cm_nx    = '0;
      if (state == ST_MEASURE) begin
         width_nx = width_cnt + 16'd1;
         sub_nx   = sub_cnt + 16'd1;
         cm_nx    = cm_cnt;
      end
      if ((state == ST_MEASURE ? sub_cnt : 16'd0) == SUB_LAST) begin
         sub_nx = 16'd0;
         cm_nx  = (state == ST_MEASURE ? cm_cnt : '0) + 1'b1;
      end
      hit_max = (width_nx == ECHO_LAST);
   end

   always_ff @(posedge clk_1m) begin
      if (rst) begin
         state     <= ST_IDLE;
         trig_d    <= 1'b0;
         wait_cnt  <= '0;
         width_cnt <= '0;
         sub_cnt   <= '0;
         cm_cnt    <= '0;
         width_q   <= '0;
         dist_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         trig_d    <= trig;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (trig_d && !trig) begin
                  state    <= ST_WAIT_RISE;
                  wait_cnt <= WAIT_LOAD;
                  busy_q   <= 1'b1;
               end
            end
            ST_WAIT_RISE: begin
               if (echo_rise) begin
                  width_cnt <= width_nx;
                  sub_cnt   <= sub_nx;
                  cm_cnt    <= cm_nx;
                  timeout_q <= hit_max;
                  state     <= hit_max ? ST_DRAIN : ST_MEASURE;
               end else if (wait_cnt <= 16'd1) begin
                  // terminal count: WAIT_MAX cycles spent without a rise
                  wait_cnt  <= '0;
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 16'd1;
               end
            end
            ST_MEASURE: begin
               if (echo_fall) begin
                  width_q <= width_cnt;
                  dist_q  <= cm_cnt;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state   <= ST_IDLE;
               end else if (echo_lvl) begin
                  width_cnt <= width_nx;
                  sub_cnt   <= sub_nx;
                  cm_cnt    <= cm_nx;
                  if (hit_max) begin
                     timeout_q <= 1'b1;
                     state     <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // width_cnt is held at ECHO_MAX here, so it saturates
               if (!echo_lvl) begin
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign res.width_us = width_q;
   assign res.dist_cm  = dist_q;
   assign res.valid    = valid_q;
   assign res.timeout  = timeout_q;
   assign res.busy     = busy_q;

endmodule

// File: tb/tb_echo_measure.sv
// Directed bench for echo_measure with scaled-down WAIT_MAX / ECHO_MAX.
module tb_echo_measure;

   localparam int TB_WAIT = 3000;
   localparam int TB_ECHO = 3800;
   localparam int TB_UPC  = 58;

   logic clk_1m = 1'b0;
   logic rst    = 1'b1;
   logic trig   = 1'b0;
   logic echo   = 1'b0;

   int checks = 0;
   int errors = 0;
   int vcnt   = 0;
   int tcnt   = 0;
   int both   = 0;

   echo_measure_if res_if ();

   echo_measure #(
      .WAIT_MAX  (TB_WAIT),
      .ECHO_MAX  (TB_ECHO),
      .US_PER_CM (TB_UPC)
   ) dut (
      .clk_1m (clk_1m),
      .rst    (rst),
      .trig   (trig),
      .echo   (echo),
      .res    (res_if)
   );

   always #5 clk_1m = ~clk_1m;

   always @(negedge clk_1m) begin
      if (res_if.valid === 1'b1) vcnt++;
      if (res_if.timeout === 1'b1) tcnt++;
      if (res_if.valid === 1'b1 && res_if.timeout === 1'b1) both++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_1m);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (res_if.busy !== 1'b0 && k < 60) begin
         tick(1);
         k++;
      end
      check(tag, 32'(k < 60), 32'd1);
   endtask

   // trig pulse, echo high n cycles starting `delay` cycles after trig fall;
   // with retrig a second trig pulse is issued 300 cycles into the echo.
   task automatic run_echo(input int delay, input int n, input bit retrig);
      trig = 1'b1;
      tick(2);
      trig = 1'b0;
      tick(delay);
      echo = 1'b1;
      if (retrig) begin
         tick(300);
         trig = 1'b1;
         tick(2);
         trig = 1'b0;
         tick(n - 302);
      end else begin
         tick(n);
      end
      echo = 1'b0;
      wait_idle("meas_done");
      tick(2);
   endtask

   initial begin
      int vs;
      int ts;
      int k;

      tick(3);
      check("rst_width", 32'(res_if.width_us), 32'd0);
      check("rst_dist", 32'(res_if.dist_cm), 32'd0);
      check("rst_valid", 32'(res_if.valid), 32'd0);
      check("rst_timeout", 32'(res_if.timeout), 32'd0);
      check("rst_busy", 32'(res_if.busy), 32'd0);
      rst = 1'b0;
      tick(2);

      // 580-cycle echo, 200 cycles after trig fall
      vs = vcnt; ts = tcnt;
      trig = 1'b1;
      tick(2);
      trig = 1'b0;
      tick(199);
      check("a_busy_armed", 32'(res_if.busy), 32'd1);
      echo = 1'b1;
      tick(580);
      echo = 1'b0;
      wait_idle("a_done");
      tick(2);
      check("a_width", 32'(res_if.width_us), 32'd580);
      check("a_dist", 32'(res_if.dist_cm), 32'd10);
      check("a_valid_cnt", 32'(vcnt - vs), 32'd1);
      check("a_timeout_cnt", 32'(tcnt - ts), 32'd0);

      // just below one centimetre
      run_echo(50, 57, 1'b0);
      check("b_width", 32'(res_if.width_us), 32'd57);
      check("b_dist", 32'(res_if.dist_cm), 32'd0);

      run_echo(50, 116, 1'b0);
      check("c_width", 32'(res_if.width_us), 32'd116);
      check("c_dist", 32'(res_if.dist_cm), 32'd2);

      // no echo -> wait timeout
      vs = vcnt; ts = tcnt;
      trig = 1'b1;
      tick(2);
      trig = 1'b0;
      k = 0;
      while (res_if.timeout !== 1'b1 && k < TB_WAIT + 20) begin
         tick(1);
         k++;
      end
      check("d_wait_cycles", 32'(k >= TB_WAIT - 1 && k <= TB_WAIT + 3), 32'd1);
      tick(2);
      check("d_busy", 32'(res_if.busy), 32'd0);
      check("d_width_hold", 32'(res_if.width_us), 32'd116);
      check("d_dist_hold", 32'(res_if.dist_cm), 32'd2);
      check("d_timeout_cnt", 32'(tcnt - ts), 32'd1);
      check("d_valid_cnt", 32'(vcnt - vs), 32'd0);

      // echo stuck high -> width timeout, drain until echo low
      vs = vcnt; ts = tcnt;
      trig = 1'b1;
      tick(2);
      trig = 1'b0;
      tick(100);
      echo = 1'b1;
      k = 0;
      while (res_if.timeout !== 1'b1 && k < TB_ECHO + 50) begin
         tick(1);
         k++;
      end
      check("e_echo_cycles", 32'(k >= TB_ECHO + 1 && k <= TB_ECHO + 5), 32'd1);
      tick(500);
      check("e_busy_drain", 32'(res_if.busy), 32'd1);
      check("e_timeout_cnt", 32'(tcnt - ts), 32'd1);
      check("e_width_hold", 32'(res_if.width_us), 32'd116);
      echo = 1'b0;
      wait_idle("e_done");
      tick(2);
      check("e_valid_cnt", 32'(vcnt - vs), 32'd0);
      check("e_timeout_once", 32'(tcnt - ts), 32'd1);

      // second trig during measurement is ignored
      vs = vcnt; ts = tcnt;
      run_echo(50, 1160, 1'b1);
      check("f_width", 32'(res_if.width_us), 32'd1160);
      check("f_dist", 32'(res_if.dist_cm), 32'd20);
      check("f_valid_cnt", 32'(vcnt - vs), 32'd1);
      tick(20);
      check("f_busy_after", 32'(res_if.busy), 32'd0);
      check("f_timeout_cnt", 32'(tcnt - ts), 32'd0);

      // reset mid-measurement discards it
      vs = vcnt; ts = tcnt;
      trig = 1'b1;
      tick(2);
      trig = 1'b0;
      tick(50);
      echo = 1'b1;
      tick(300);
      rst = 1'b1;
      tick(1);
      check("g_width", 32'(res_if.width_us), 32'd0);
      check("g_dist", 32'(res_if.dist_cm), 32'd0);
      check("g_busy", 32'(res_if.busy), 32'd0);
      check("g_valid", 32'(res_if.valid), 32'd0);
      check("g_timeout", 32'(res_if.timeout), 32'd0);
      rst = 1'b0;
      tick(279);
      echo = 1'b0;
      tick(20);
      check("g_valid_cnt", 32'(vcnt - vs), 32'd0);
      check("g_timeout_cnt", 32'(tcnt - ts), 32'd0);
      check("g_busy_after", 32'(res_if.busy), 32'd0);

      vs = vcnt;
      run_echo(100, 290, 1'b0);
      check("h_width", 32'(res_if.width_us), 32'd290);
      check("h_dist", 32'(res_if.dist_cm), 32'd5);
      check("h_valid_cnt", 32'(vcnt - vs), 32'd1);

      check("valid_timeout_overlap", 32'(both), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
